// File: rtl/stream_frame_accum.sv
// stream_frame_accum
//   Sums frames of FRAME_LEN input words, or fewer when t0_last ends a frame
//   early. Each frame produces one registered result beat carrying the sum,
//   the beat count and a wrap flag.
//
// Ports
//   clk       rising-edge clock
//   rstf      asynchronous, active-low reset
//   t0_data   input word
//   t0_valid  input beat valid
//   t0_last   early end-of-frame marker, qualified by t0_valid
//   t0_ready  input beat may be accepted this cycle
//   i0_sum    frame sum, modulo 2^SUM_W
//   i0_count  beats in the frame (1..FRAME_LEN)
//   i0_ovf    sum wrapped past 2^SUM_W somewhere in the frame
//   i0_valid  result beat valid
//   i0_ready  sink accepts result
//
// state        | meaning
// IDLE         | cnt == 0, no partial frame held
// ACCUM        | 0 < cnt < FRAME_LEN, partial frame in acc/ovf_acc
// output full  | i0_valid == 1, result waiting for the sink (orthogonal)

module stream_frame_accum #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 4,
    parameter int SUM_W     = 34,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic [DATA_W-1:0] t0_data,
    input  logic              t0_valid,
    input  logic              t0_last,
    output logic              t0_ready,
    output logic [SUM_W-1:0]  i0_sum,
    output logic [CNT_W-1:0]  i0_count,
    output logic              i0_ovf,
    output logic              i0_valid,
    input  logic              i0_ready
);

    generate
        if (SUM_W < DATA_W) begin : g_bad_sum_w
            $error("stream_frame_accum: SUM_W must be >= DATA_W");
        end
        if (FRAME_LEN < 1) begin : g_bad_frame_len
            $error("stream_frame_accum: FRAME_LEN must be >= 1");
        end
    endgenerate

    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;

    logic             accept;
    logic             xfer;
    logic [SUM_W:0]   data_ext;
    logic [SUM_W:0]   sum_wide;
    logic [SUM_W-1:0] next_sum;
    logic             next_ovf;
    logic [CNT_W-1:0] next_cnt;
    logic             complete;

    // A stalled result blocks new input, even mid-frame, so the accumulator
    // never has to hold a finished frame alongside a pending one.
    assign t0_ready = ~i0_valid | i0_ready;
    assign accept   = t0_valid & t0_ready;
    assign xfer     = i0_valid & i0_ready;

    // One extra bit on the add captures the carry out of the result width.
    assign data_ext = {{(SUM_W + 1 - DATA_W){1'b0}}, t0_data};
    assign sum_wide = {1'b0, acc} + data_ext;
    assign next_sum = sum_wide[SUM_W-1:0];
    assign next_ovf = ovf_acc | sum_wide[SUM_W];
    assign next_cnt = cnt + CNT_W'(1);

    // t0_last on the FRAME_LEN-th beat is still a single completion.
    assign complete = (next_cnt == CNT_W'(FRAME_LEN)) | t0_last;

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            acc      <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            i0_sum   <= '0;
            i0_count <= '0;
            i0_ovf   <= 1'b0;
            i0_valid <= 1'b0;
        end else if (accept && complete) begin
            // Loading a new result also covers a same-edge output transfer,
            // which keeps single-beat frames flowing at one per cycle.
            i0_sum   <= next_sum;
            i0_count <= next_cnt;
            i0_ovf   <= next_ovf;
            i0_valid <= 1'b1;
            acc      <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
        end else begin
            if (accept) begin
                acc     <= next_sum;
                cnt     <= next_cnt;
                ovf_acc <= next_ovf;
            end
            if (xfer) begin
                i0_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_frame_accum.sv
// tb_stream_frame_accum
//   Directed bench for stream_frame_accum. Three instances share clock and
//   reset: the default build (FRAME_LEN=4, SUM_W=34), a SUM_W=32 build for
//   wrap behaviour, and a FRAME_LEN=1 build for back-to-back results.
//   Inputs are driven 1 ns after the rising edge; outputs are sampled there.

module tb_stream_frame_accum;

    logic clk;
    logic rstf;

    // default build
    logic [31:0] a_data;
    logic        a_valid, a_last, a_ready;
    logic [33:0] a_sum;
    logic [2:0]  a_count;
    logic        a_ovf, a_ovalid, a_iready;

    // SUM_W = 32 build
    logic [31:0] b_data;
    logic        b_valid, b_last, b_ready;
    logic [31:0] b_sum;
    logic [2:0]  b_count;
    logic        b_ovf, b_ovalid, b_iready;

    // FRAME_LEN = 1 build
    logic [31:0] c_data;
    logic        c_valid, c_last, c_ready;
    logic [33:0] c_sum;
    logic [0:0]  c_count;
    logic        c_ovf, c_ovalid, c_iready;

    int n_chk  = 0;
    int n_fail = 0;

    stream_frame_accum u_dut_a (
        .clk(clk), .rstf(rstf),
        .t0_data(a_data), .t0_valid(a_valid), .t0_last(a_last), .t0_ready(a_ready),
        .i0_sum(a_sum), .i0_count(a_count), .i0_ovf(a_ovf), .i0_valid(a_ovalid),
        .i0_ready(a_iready)
    );

    stream_frame_accum #(.SUM_W(32)) u_dut_b (
        .clk(clk), .rstf(rstf),
        .t0_data(b_data), .t0_valid(b_valid), .t0_last(b_last), .t0_ready(b_ready),
        .i0_sum(b_sum), .i0_count(b_count), .i0_ovf(b_ovf), .i0_valid(b_ovalid),
        .i0_ready(b_iready)
    );

    stream_frame_accum #(.FRAME_LEN(1)) u_dut_c (
        .clk(clk), .rstf(rstf),
        .t0_data(c_data), .t0_valid(c_valid), .t0_last(c_last), .t0_ready(c_ready),
        .i0_sum(c_sum), .i0_count(c_count), .i0_ovf(c_ovf), .i0_valid(c_ovalid),
        .i0_ready(c_iready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [31:0] d, input logic l);
        a_data  = d;
        a_valid = 1'b1;
        a_last  = l;
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic b_beat(input logic [31:0] d);
        b_data  = d;
        b_valid = 1'b1;
        b_last  = 1'b0;
        tick();
        b_valid = 1'b0;
    endtask

    initial begin
        rstf = 1'b0;
        a_data = '0; a_valid = 0; a_last = 0; a_iready = 1;
        b_data = '0; b_valid = 0; b_last = 0; b_iready = 1;
        c_data = '0; c_valid = 0; c_last = 0; c_iready = 1;
        tick();
        tick();

        // reset state
        check("rst_sum",   a_sum,    0);
        check("rst_count", a_count,  0);
        check("rst_ovf",   a_ovf,    0);
        check("rst_valid", a_ovalid, 0);
        check("rst_ready", a_ready,  1);
        rstf = 1'b1;
        tick();

        // full frame 4,8,12,16
        a_beat(32'd4, 0);
        a_beat(32'd8, 0);
        a_beat(32'd12, 0);
        check("full_no_early_valid", a_ovalid, 0);
        a_beat(32'd16, 0);
        check("full_valid", a_ovalid, 1);
        check("full_sum",   a_sum,    40);
        check("full_count", a_count,  4);
        check("full_ovf",   a_ovf,    0);
        tick();
        check("full_valid_one_cycle", a_ovalid, 0);

        // early end 0x100, 0x200+last
        a_beat(32'h100, 0);
        a_beat(32'h200, 1);
        check("early_valid", a_ovalid, 1);
        check("early_sum",   a_sum,    34'h300);
        check("early_count", a_count,  2);
        tick();
        check("early_drain", a_ovalid, 0);

        // next frame starts from zero; then hold the result for 5 cycles
        a_beat(32'd5, 0);
        a_beat(32'd6, 1);
        check("restart_sum",   a_sum,   11);
        check("restart_count", a_count, 2);
        a_iready = 1'b0;
        a_data   = 32'd100;
        a_valid  = 1'b1;
        a_last   = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_low",   a_ready,  0);
            check("bp_valid_hold",  a_ovalid, 1);
            check("bp_sum_hold",    a_sum,    11);
            check("bp_count_hold",  a_count,  2);
            tick();
        end
        a_iready = 1'b1;
        #1;
        check("bp_ready_rise", a_ready, 1);
        tick();
        // old result left and the pending single-beat frame loaded same edge
        a_valid = 1'b0;
        a_last  = 1'b0;
        check("bp_swap_valid", a_ovalid, 1);
        check("bp_swap_sum",   a_sum,    100);
        check("bp_swap_count", a_count,  1);
        tick();
        check("bp_swap_drain", a_ovalid, 0);

        // wide accumulator does not wrap on four max words
        a_beat(32'hFFFF_FFFF, 0);
        a_beat(32'hFFFF_FFFF, 0);
        a_beat(32'hFFFF_FFFF, 0);
        a_beat(32'hFFFF_FFFF, 0);
        check("wide_sum", a_sum, 34'h3_FFFF_FFFC);
        check("wide_ovf", a_ovf, 0);
        tick();

        // overflow on the SUM_W=32 build
        b_beat(32'hFFFF_FFFC);
        b_beat(32'hFFFF_FFFC);
        b_beat(32'hFFFF_FFFC);
        b_beat(32'hFFFF_FFFC);
        check("ovf_valid", b_ovalid, 1);
        check("ovf_sum",   b_sum,    32'hFFFF_FFF0);
        check("ovf_flag",  b_ovf,    1);
        b_beat(32'd1);
        b_beat(32'd1);
        b_beat(32'd1);
        b_beat(32'd1);
        check("ovf_next_sum",  b_sum,    4);
        check("ovf_next_flag", b_ovf,    0);
        check("ovf_next_cnt",  b_count,  4);
        tick();

        // back-to-back single-beat frames
        for (int i = 0; i < 8; i++) begin
            c_data  = 32'(i);
            c_valid = 1'b1;
            c_last  = 1'b0;
            check("b2b_ready", c_ready, 1);
            tick();
            check("b2b_valid", c_ovalid, 1);
            check("b2b_sum",   c_sum,    64'(i));
            check("b2b_count", c_count,  1);
        end
        c_valid = 1'b0;
        tick();
        check("b2b_drain", c_ovalid, 0);

        // reset in the middle of a frame
        a_beat(32'd4, 0);
        a_beat(32'd4, 0);
        rstf = 1'b0;
        #1;
        check("mid_rst_sum",   a_sum,    0);
        check("mid_rst_count", a_count,  0);
        check("mid_rst_ovf",   a_ovf,    0);
        check("mid_rst_valid", a_ovalid, 0);
        tick();
        rstf = 1'b1;
        tick();
        a_beat(32'd1, 0);
        a_beat(32'd1, 0);
        check("post_rst_no_stale", a_ovalid, 0);
        a_beat(32'd1, 0);
        check("post_rst_no_early", a_ovalid, 0);
        a_beat(32'd1, 0);
        check("post_rst_valid", a_ovalid, 1);
        check("post_rst_sum",   a_sum,    4);
        check("post_rst_count", a_count,  4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
